// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: access sizes, FSM encoding, wait-counter width.
package lsu_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  localparam int CNT_W = 4;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_RD     = 3'd1,
    ST_WR     = 3'd2,
    ST_RMW_RD = 3'd3,
    ST_RMW_WR = 3'd4
  } lsu_state_e;

  // Size 2'b11 is handled like a word everywhere.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lo);
    case (size)
      SZ_BYTE: is_misaligned = 1'b0;
      SZ_HALF: is_misaligned = lo[0];
      default: is_misaligned = (lo != 2'b00);
    endcase
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Combinational little-endian lane handling: extract+extend for loads, lane merge for sub-word stores.
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [31:0] rword,
  input  logic [1:0]  size,
  input  logic        uns,
  input  logic [1:0]  lo,
  input  logic [31:0] wdata,
  output logic [31:0] ldata,
  output logic [31:0] merged
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  always_comb begin
    byte_v = rword[{lo, 3'b000} +: 8];
    half_v = lo[1] ? rword[31:16] : rword[15:0];
    ldata  = rword;
    merged = wdata;
    case (size)
      SZ_BYTE: begin
        ldata  = {{24{~uns & byte_v[7]}}, byte_v};
        merged = rword;
        merged[{lo, 3'b000} +: 8] = wdata[7:0];
      end
      SZ_HALF: begin
        ldata  = {{16{~uns & half_v[15]}}, half_v};
        merged = rword;
        if (lo[1]) merged[31:16] = wdata[15:0];
        else       merged[15:0]  = wdata[15:0];
      end
      default: begin
        ldata  = rword;
        merged = wdata;
      end
    endcase
  end

endmodule

// File: rtl/dmem_access_unit.sv
// Load/store unit between the MEM stage and word-wide data memory; sub-word stores use read-modify-write.
// Optional feature macro: LSU_MISALIGN_CHECK_EN (misaligned half/word requests answer with resp_err).
module dmem_access_unit
  import lsu_pkg::*;
#(
  parameter int unsigned RD_WAIT = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  output logic [2:0]  dbg_state
);

  localparam logic [CNT_W-1:0] RD_WAIT_C = CNT_W'(RD_WAIT);

  // Handshake: a request transfers on a rising edge where req_valid && req_ready; req_ready is
  // high only in IDLE; resp_valid is a single-cycle pulse with no back-pressure.
  lsu_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [1:0]       size_q, lo_q;
  logic             uns_q;
  logic [31:0]      wdata_q;
  logic             accept, bad, last_rd;
  logic [31:0]      load_data, merged;

  assign req_ready = (state_q == ST_IDLE);
  assign accept    = req_valid && req_ready;
  assign last_rd   = (cnt_q == RD_WAIT_C);
  assign dbg_state = state_q;

`ifdef LSU_MISALIGN_CHECK_EN
  logic err_q;
  assign bad      = is_misaligned(req_size, req_addr[1:0]);
  assign resp_err = err_q;
`else
  assign bad      = 1'b0;
  assign resp_err = 1'b0;
`endif

  lsu_lane_align u_align (
    .rword  (mem_rdata),
    .size   (size_q),
    .uns    (uns_q),
    .lo     (lo_q),
    .wdata  (wdata_q),
    .ldata  (load_data),
    .merged (merged)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (accept && !bad) begin
          if (!req_we)          state_d = ST_RD;
          else if (req_size[1]) state_d = ST_WR;
          else                  state_d = ST_RMW_RD;
        end
      end
      ST_RD:     if (last_rd) state_d = ST_IDLE;
      ST_WR:     state_d = ST_IDLE;
      ST_RMW_RD: if (last_rd) state_d = ST_RMW_WR;
      ST_RMW_WR: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q      <= '0;
      size_q     <= SZ_BYTE;
      lo_q       <= 2'b00;
      uns_q      <= 1'b0;
      wdata_q    <= '0;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
`ifdef LSU_MISALIGN_CHECK_EN
      err_q      <= 1'b0;
`endif
    end else begin
      resp_valid <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (accept && bad) begin
            resp_valid <= 1'b1;
            resp_rdata <= '0;
`ifdef LSU_MISALIGN_CHECK_EN
            err_q      <= 1'b1;
`endif
          end else if (accept) begin
            cnt_q    <= '0;
            size_q   <= req_size;
            lo_q     <= req_addr[1:0];
            uns_q    <= req_unsigned;
            wdata_q  <= req_wdata;
            mem_addr <= {req_addr[31:2], 2'b00};
            // Word stores need no read phase, so the write goes out on the very next cycle.
            if (req_we && req_size[1]) begin
              mem_we    <= 1'b1;
              mem_wdata <= req_wdata;
            end
          end
        end
        ST_RD: begin
          if (last_rd) begin
            resp_valid <= 1'b1;
            resp_rdata <= load_data;
`ifdef LSU_MISALIGN_CHECK_EN
            err_q      <= 1'b0;
`endif
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        ST_RMW_RD: begin
          if (last_rd) begin
            mem_we    <= 1'b1;
            mem_wdata <= merged;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        ST_WR, ST_RMW_WR: begin
          mem_we     <= 1'b0;
          resp_valid <= 1'b1;
          resp_rdata <= '0;
`ifdef LSU_MISALIGN_CHECK_EN
          err_q      <= 1'b0;
`endif
        end
        default: mem_we <= 1'b0;
      endcase
    end
  end

endmodule
